axis_apb_ethernet_rx_buffer: RTL and testbench

// Receive-side frame buffer. Accepts Ethernet frames from the MAC on 32-bit AXI-Stream and stores them whole.

---
 rtl/axis_apb_ethernet_rx_buffer.sv | 203 ++++++++++++++++++++
 tb/tb_axis_apb_ethernet_rx_buffer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_apb_ethernet_rx_buffer.sv
// Receive frame buffer: stores whole AXI-Stream Ethernet frames, commits good ones,
// and lets software read them out over APB as a length followed by data words.
module axis_apb_ethernet_rx_buffer #(
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned HDR_DEPTH  = 32,
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                  pclk,
  input  logic                  preset_n,
  input  logic                  link_up,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic [31:0]           s_tdata,
  input  logic [3:0]            s_tkeep,
  input  logic                  s_tlast,
  input  logic                  s_tuser,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [31:0]           pwdata,
  output logic [31:0]           prdata,
  output logic                  pready,
  output logic                  pslverr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned HW = $clog2(HDR_DEPTH);

  localparam logic [ADDR_WIDTH-1:0] A_STAT  = ADDR_WIDTH'(32'h00);
  localparam logic [ADDR_WIDTH-1:0] A_LEN   = ADDR_WIDTH'(32'h20);
  localparam logic [ADDR_WIDTH-1:0] A_POP   = ADDR_WIDTH'(32'h40);
  localparam logic [ADDR_WIDTH-1:0] A_RX    = ADDR_WIDTH'(32'h60);
  localparam logic [ADDR_WIDTH-1:0] A_DROPS = ADDR_WIDTH'(32'h80);

  logic [31:0]   ram [DEPTH];
  logic [31:0]   ram_q;
  logic [PW-1:0] wr_ptr, frame_start, rd_ptr;
  logic [11:0]   byte_cnt;
  logic          f_err, f_ovf, f_big, in_sync;

  logic [10:0]   hdr_mem [HDR_DEPTH];
  logic [HW-1:0] hdr_wi, hdr_ri;
  logic [HW:0]   hdr_cnt;
  logic          hdr_ne_q;

  logic [9:0]    rd_words;
  logic [15:0]   drops;

  // ---------------- write side ----------------
  logic [2:0]    beat_bytes;
  logic [11:0]   new_cnt;
  logic [PW-1:0] used, wr_next;
  logic          full, beat, wr_en, new_err, new_ovf, new_big, zero_len;
  logic          hdr_full, bad, commit, drop;

  assign s_tready   = 1'b1;
  assign beat_bytes = 3'(s_tkeep[0]) + 3'(s_tkeep[1]) + 3'(s_tkeep[2]) + 3'(s_tkeep[3]);
  assign used       = wr_ptr - rd_ptr;
  assign full       = (used == PW'(DEPTH));
  assign beat       = s_tvalid & link_up & in_sync;
  assign wr_en      = beat & ~full;
  assign wr_next    = wr_ptr + PW'(wr_en);
  assign new_cnt    = byte_cnt + 12'(beat_bytes);
  assign new_big    = f_big | (new_cnt > 12'd2047);
  assign new_err    = f_err | s_tuser;
  assign new_ovf    = f_ovf | full;
  // the count may wrap once oversize is flagged, so only trust zero while not oversize
  assign zero_len   = ~new_big & (new_cnt == 12'd0);
  assign hdr_full   = (hdr_cnt == (HW+1)'(HDR_DEPTH));
  assign bad        = new_err | new_ovf | new_big | hdr_full;
  assign commit     = beat & s_tlast & ~zero_len & ~bad;
  assign drop       = beat & s_tlast & ~zero_len & bad;

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      wr_ptr      <= '0;
      frame_start <= '0;
      byte_cnt    <= '0;
      f_err       <= 1'b0;
      f_ovf       <= 1'b0;
      f_big       <= 1'b0;
      in_sync     <= 1'b0;
    end else if (!link_up) begin
      wr_ptr   <= frame_start;
      in_sync  <= 1'b0;
      byte_cnt <= '0;
      f_err    <= 1'b0;
      f_ovf    <= 1'b0;
      f_big    <= 1'b0;
    end else if (s_tvalid && !in_sync) begin
      if (s_tlast) in_sync <= 1'b1;
    end else if (beat) begin
      if (s_tlast) begin
        byte_cnt <= '0;
        f_err    <= 1'b0;
        f_ovf    <= 1'b0;
        f_big    <= 1'b0;
        if (commit) begin
          wr_ptr      <= wr_next;
          frame_start <= wr_next;
        end else begin
          wr_ptr <= frame_start;
        end
      end else begin
        wr_ptr   <= wr_next;
        byte_cnt <= new_cnt;
        f_err    <= new_err;
        f_ovf    <= new_ovf;
        f_big    <= new_big;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (wr_en) ram[wr_ptr[AW-1:0]] <= s_tdata;
    ram_q <= ram[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge pclk) begin
    if (commit) hdr_mem[hdr_wi] <= new_cnt[10:0];
  end

  // ---------------- APB / read side ----------------
  logic        access, is_stat, is_len, is_pop, is_rx, is_drops;
  logic        hdr_ne, rx_rd, rx_ok, pop_wr, hdr_pop, last_word, drops_clr;
  logic        map_err, dir_err, slv_err;
  logic [10:0] head_len;
  logic [9:0]  head_words, words_left;
  logic [31:0] rdata;

  assign access     = psel & penable;
  assign pready     = access;
  assign is_stat    = (paddr == A_STAT);
  assign is_len     = (paddr == A_LEN);
  assign is_pop     = (paddr == A_POP);
  assign is_rx      = (paddr == A_RX);
  assign is_drops   = (paddr == A_DROPS);

  assign hdr_ne     = (hdr_cnt != '0);
  assign head_len   = hdr_mem[hdr_ri];
  assign head_words = 10'((12'(head_len) + 12'd3) >> 2);
  assign words_left = head_words - rd_words;
  assign last_word  = (words_left == 10'd1);

  // ram_q was fetched on the setup edge, so it is only meaningful if a frame was already there
  assign rx_rd      = access & ~pwrite & is_rx;
  assign rx_ok      = rx_rd & hdr_ne_q & hdr_ne;
  assign pop_wr     = access & pwrite & is_pop & hdr_ne;
  assign hdr_pop    = (rx_ok & last_word) | pop_wr;
  assign drops_clr  = access & pwrite & is_drops;

  assign map_err    = ~(is_stat | is_len | is_pop | is_rx | is_drops);
  assign dir_err    = pwrite ? (is_stat | is_len | is_rx) : is_pop;
  assign slv_err    = access & (map_err | dir_err | (rx_rd & ~rx_ok));
  assign pslverr    = slv_err;

  always_comb begin
    rdata = '0;
    if (access && !pwrite && !slv_err) begin
      if (is_stat)       rdata = {30'b0, link_up, hdr_ne};
      else if (is_len)   rdata = hdr_ne ? {21'b0, head_len} : '0;
      else if (is_rx)    rdata = ram_q;
      else if (is_drops) rdata = {16'b0, drops};
    end
  end
  assign prdata = rdata;

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      rd_ptr   <= '0;
      rd_words <= '0;
      hdr_wi   <= '0;
      hdr_ri   <= '0;
      hdr_cnt  <= '0;
      hdr_ne_q <= 1'b0;
      drops    <= '0;
    end else begin
      hdr_ne_q <= hdr_ne;
      if (rx_ok) begin
        rd_ptr   <= rd_ptr + PW'(1);
        rd_words <= last_word ? '0 : rd_words + 10'd1;
      end else if (pop_wr) begin
        rd_ptr   <= rd_ptr + PW'(words_left);
        rd_words <= '0;
      end
      if (commit)  hdr_wi <= hdr_wi + HW'(1);
      if (hdr_pop) hdr_ri <= hdr_ri + HW'(1);
      case ({commit, hdr_pop})
        2'b10:   hdr_cnt <= hdr_cnt + (HW+1)'(1);
        2'b01:   hdr_cnt <= hdr_cnt - (HW+1)'(1);
        default: hdr_cnt <= hdr_cnt;
      endcase
      if (drops_clr)                drops <= '0;
      else if (drop && drops != '1) drops <= drops + 16'd1;
    end
  end

  logic unused_bits;
  assign unused_bits = ^pwdata;

endmodule

// File: tb/tb_axis_apb_ethernet_rx_buffer.sv
// Directed bench with a word/length scoreboard for the RX frame buffer (default and DEPTH=16 instances).
module tb_axis_apb_ethernet_rx_buffer;

  logic        pclk = 1'b0;
  logic        preset_n, link_up;
  logic        s_tvalid, s_tlast, s_tuser;
  logic [31:0] s_tdata;
  logic [3:0]  s_tkeep;
  logic        psel, penable, pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata;

  logic        tready_a, pready_a, pslverr_a, tready_b, pready_b, pslverr_b;
  logic [31:0] prdata_a, prdata_b;
  logic        use16;
  logic [31:0] prdata_m;
  logic        pready_m, pslverr_m, tready_m;

  assign prdata_m  = use16 ? prdata_b  : prdata_a;
  assign pready_m  = use16 ? pready_b  : pready_a;
  assign pslverr_m = use16 ? pslverr_b : pslverr_a;
  assign tready_m  = use16 ? tready_b  : tready_a;

  always #5 pclk = ~pclk;

  axis_apb_ethernet_rx_buffer dut (
    .pclk(pclk), .preset_n(preset_n), .link_up(link_up),
    .s_tvalid(s_tvalid), .s_tready(tready_a), .s_tdata(s_tdata), .s_tkeep(s_tkeep),
    .s_tlast(s_tlast), .s_tuser(s_tuser),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata_a), .pready(pready_a), .pslverr(pslverr_a)
  );

  axis_apb_ethernet_rx_buffer #(.DEPTH(16)) dut16 (
    .pclk(pclk), .preset_n(preset_n), .link_up(link_up),
    .s_tvalid(s_tvalid), .s_tready(tready_b), .s_tdata(s_tdata), .s_tkeep(s_tkeep),
    .s_tlast(s_tlast), .s_tuser(s_tuser),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata_b), .pready(pready_b), .pslverr(pslverr_b)
  );

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_words[$];
  int unsigned exp_lens[$];
  int unsigned words_rd;
  int unsigned exp_drops;
  logic        last_ready;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    exp_words.delete();
    exp_lens.delete();
    words_rd  = 0;
    exp_drops = 0;
  endtask

  task automatic do_reset();
    preset_n = 1'b0;
    repeat (2) @(posedge pclk);
    #1 preset_n = 1'b1;
    clear_model();
  endtask

  task automatic beat(input logic [31:0] d, input logic [3:0] k, input logic l, input logic u);
    s_tvalid = 1'b1; s_tdata = d; s_tkeep = k; s_tlast = l; s_tuser = u;
    @(posedge pclk);
    #1 s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
  endtask

  // kind: 0 = committed, 1 = counted drop, 2 = silently discarded
  task automatic send_frame(input int unsigned len, input int err_beat, input int kind);
    int unsigned nb, rem;
    logic [31:0] d;
    logic [3:0]  k;
    nb = (len + 3) / 4;
    for (int b = 0; b < int'(nb); b++) begin
      d   = $urandom;
      rem = len - 4 * b;
      k   = (rem >= 4) ? 4'hF : (rem == 3) ? 4'h7 : (rem == 2) ? 4'h3 : 4'h1;
      beat(d, k, b == int'(nb) - 1, b == err_beat);
      if (kind == 0) exp_words.push_back(d);
    end
    if (kind == 0) exp_lens.push_back(len);
    if (kind == 1) exp_drops++;
  endtask

  task automatic apb(input logic wr, input logic [15:0] addr, output logic [31:0] rd, output logic err);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = $urandom;
    @(posedge pclk);
    #1 penable = 1'b1;
    #1 rd = prdata_m; err = pslverr_m; last_ready = pready_m;
    @(posedge pclk);
    #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic rd_word(input string tag);
    logic [31:0] d;
    logic        e;
    apb(1'b0, 16'h60, d, e);
    if (exp_lens.size() > 0) begin
      check({tag, "_data"}, d, exp_words.pop_front());
      check({tag, "_err"}, 32'(e), 32'd0);
      words_rd++;
      if (words_rd == (exp_lens[0] + 3) / 4) begin
        void'(exp_lens.pop_front());
        words_rd = 0;
      end
    end else begin
      check({tag, "_empty_data"}, d, 32'd0);
      check({tag, "_empty_err"}, 32'(e), 32'd1);
    end
  endtask

  task automatic read_all(input string tag);
    while (exp_lens.size() > 0) rd_word(tag);
  endtask

  task automatic pop_frame(input string tag);
    logic [31:0] d;
    logic        e;
    int unsigned rem;
    apb(1'b1, 16'h40, d, e);
    check({tag, "_pop_err"}, 32'(e), 32'd0);
    if (exp_lens.size() > 0) begin
      rem = (exp_lens[0] + 3) / 4 - words_rd;
      repeat (rem) void'(exp_words.pop_front());
      void'(exp_lens.pop_front());
      words_rd = 0;
    end
  endtask

  task automatic check_stat_len(input string tag);
    logic [31:0] d;
    logic        e;
    apb(1'b0, 16'h00, d, e);
    check({tag, "_stat"}, d, {30'b0, link_up, exp_lens.size() > 0});
    apb(1'b0, 16'h20, d, e);
    check({tag, "_len"}, d, (exp_lens.size() > 0) ? exp_lens[0] : 32'd0);
  endtask

  task automatic check_drops(input string tag);
    logic [31:0] d;
    logic        e;
    apb(1'b0, 16'h80, d, e);
    check({tag, "_drops"}, d, exp_drops);
  endtask

  task automatic check_err(input string tag, input logic wr, input logic [15:0] addr, input logic exp_err);
    logic [31:0] d;
    logic        e;
    apb(wr, addr, d, e);
    check({tag, "_slverr"}, 32'(e), 32'(exp_err));
    if (!wr) check({tag, "_prdata"}, d, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    preset_n = 1'b0; link_up = 1'b1; use16 = 1'b0;
    s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; s_tuser = 1'b0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    last_ready = 1'b0;

    // reset state
    do_reset();
    check("rst_pready", 32'(pready_m), 32'd0);
    check("rst_prdata", prdata_m, 32'd0);
    check("rst_pslverr", 32'(pslverr_m), 32'd0);
    check("tready", 32'(tready_m), 32'd1);
    check_stat_len("rst");
    check("access_pready", 32'(last_ready), 32'd1);
    check_drops("rst");
    beat(32'h0, 4'h0, 1'b1, 1'b0);   // lone tlast brings the receiver into sync

    // 60-byte frame
    send_frame(60, -1, 0);
    check_stat_len("f60");
    read_all("f60");
    check_stat_len("f60_done");

    // 61-byte frame, then an over-read
    send_frame(61, -1, 0);
    check_stat_len("f61");
    read_all("f61");
    rd_word("f61_extra");

    // errored frame followed by a good one
    send_frame(40, 4, 1);
    send_frame(64, -1, 0);
    check_drops("tuser");
    check_stat_len("f64");
    read_all("f64");

    // error responses; POP on empty is harmless
    check_err("wr_stat", 1'b1, 16'h00, 1'b1);
    check_err("wr_len", 1'b1, 16'h20, 1'b1);
    check_err("rd_pop", 1'b0, 16'h40, 1'b1);
    check_err("unmapped04", 1'b0, 16'h04, 1'b1);
    check_err("unmappedA0", 1'b0, 16'hA0, 1'b1);
    pop_frame("pop_empty");

    // two frames queued, partial read, POP, then clear DROPS
    send_frame(48, -1, 0);
    send_frame(20, -1, 0);
    repeat (3) rd_word("two_f1");
    check_err("wr_rx", 1'b1, 16'h60, 1'b1);
    rd_word("two_f1_after_wr");
    pop_frame("two");
    check_stat_len("two_f2");
    read_all("two_f2");
    check_err("clr_drops", 1'b1, 16'h80, 1'b0);
    exp_drops = 0;
    check_drops("cleared");

    // oversize boundary
    send_frame(2048, -1, 1);
    check_drops("oversize");
    send_frame(2047, -1, 0);
    check_stat_len("max_len");
    pop_frame("max_len");
    check_stat_len("max_len_popped");

    // header FIFO full
    for (int i = 0; i < 32; i++) send_frame(4, -1, 0);
    send_frame(4, -1, 1);
    check_drops("hdr_full");
    check_stat_len("hdr_full");
    read_all("hdr_full");

    // zero-length frame is dropped silently
    beat($urandom, 4'h0, 1'b0, 1'b0);
    beat($urandom, 4'h0, 1'b1, 1'b0);
    check_drops("zero_len");
    check_stat_len("zero_len");

    // reset pulse mid-frame; the rest of that frame is discarded
    for (int b = 0; b < 5; b++) beat($urandom, 4'hF, 1'b0, 1'b0);
    preset_n = 1'b0;
    beat($urandom, 4'hF, 1'b0, 1'b0);
    preset_n = 1'b1;
    clear_model();
    for (int b = 6; b < 10; b++) beat($urandom, 4'hF, b == 9, 1'b0);
    send_frame(64, -1, 0);
    check_stat_len("mid_rst");
    check_drops("mid_rst");
    read_all("mid_rst");
    check_stat_len("mid_rst_done");

    // link drop mid-frame
    for (int b = 0; b < 5; b++) beat($urandom, 4'hF, 1'b0, 1'b0);
    link_up = 1'b0;
    beat($urandom, 4'hF, 1'b0, 1'b0);
    check_stat_len("link_down");
    link_up = 1'b1;
    for (int b = 6; b < 10; b++) beat($urandom, 4'hF, b == 9, 1'b0);
    send_frame(64, -1, 0);
    check_stat_len("link_up");
    check_drops("link");
    read_all("link");

    // DEPTH=16 instance: overflow drops and pointer wrap
    use16 = 1'b1;
    do_reset();
    beat(32'h0, 4'h0, 1'b1, 1'b0);
    send_frame(80, -1, 1);
    check_drops("d16_ovf");
    check_stat_len("d16_ovf");
    send_frame(40, -1, 0);
    send_frame(40, -1, 1);
    check_drops("d16_ovf2");
    check_stat_len("d16_a");
    read_all("d16_a");
    send_frame(40, -1, 0);
    check_stat_len("d16_wrap");
    read_all("d16_wrap");
    check_stat_len("d16_done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
